// File: rtl/blk_addr_alloc.sv
// Shared free-block allocator: circular free list of SRAM block addresses with round-robin grant.
// Optional macro BLK_ALLOC_BYPASS_EN forwards a release straight to a pending requester when the list is empty.
module blk_addr_alloc #(
    parameter int PORT_NUM = 16,
    parameter int ADDR_W   = 11,
    parameter int BLK_NUM  = 2048
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [PORT_NUM-1:0] i_addr_req,
    output logic [ADDR_W-1:0]   o_blk_addr,
    output logic [PORT_NUM-1:0] o_blk_addr_vld,
    input  logic                i_rel_vld,
    input  logic [ADDR_W-1:0]   i_rel_addr,
    output logic                o_ready,
    output logic                o_rel_err,
    output logic [ADDR_W:0]     o_free_cnt
);

    localparam int PTR_W = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(BLK_NUM);
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(BLK_NUM - 1);
    localparam logic [PTR_W:0]    PORT_CNT = (PTR_W+1)'(PORT_NUM);

    logic [0:0]          state_q,        state_d;
    logic [ADDR_W-1:0]   init_cnt_q,     init_cnt_d;
    logic [ADDR_W-1:0]   rd_ptr_q,       rd_ptr_d;
    logic [ADDR_W-1:0]   wr_ptr_q,       wr_ptr_d;
    logic [ADDR_W:0]     count_q,        count_d;
    logic [PORT_NUM-1:0] pending_q,      pending_d;
    logic [PTR_W-1:0]    rr_ptr_q,       rr_ptr_d;
    logic [ADDR_W-1:0]   blk_addr_q,     blk_addr_d;
    logic [PORT_NUM-1:0] blk_addr_vld_q, blk_addr_vld_d;
    logic                ready_q,        ready_d;
    logic                rel_err_q,      rel_err_d;

    logic [ADDR_W-1:0]   free_list_q [BLK_NUM];

    logic                grant_found;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W:0]      scan_sum;
    logic [PTR_W:0]      rr_sum;
    logic [PORT_NUM-1:0] grant_onehot;
    logic                in_run;
    logic                list_empty;
    logic                list_full;
    logic                bypass_take;
    logic                pop;
    logic                grant;
    logic                push;
    logic                rel_err_set;
    logic [ADDR_W-1:0]   grant_data;
    logic                list_we;
    logic [ADDR_W-1:0]   list_waddr;
    logic [ADDR_W-1:0]   list_wdata;

    function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    // Round-robin scan: first pending channel at or after rr_ptr, wrapping modulo PORT_NUM.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        scan_sum    = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
            scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
            if (scan_sum >= PORT_CNT) begin
                scan_sum = scan_sum - PORT_CNT;
            end
            if (!grant_found && pending_q[scan_sum[PTR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = scan_sum[PTR_W-1:0];
            end
        end
        rr_sum = {1'b0, grant_idx} + 1'b1;
        if (rr_sum >= PORT_CNT) begin
            rr_sum = '0;
        end
        grant_onehot = {{(PORT_NUM-1){1'b0}}, 1'b1} << grant_idx;
    end

    always_comb begin
        in_run     = (state_q == ST_RUN);
        list_empty = (count_q == '0);
        list_full  = (count_q == CNT_FULL);
`ifdef BLK_ALLOC_BYPASS_EN
        bypass_take = in_run && list_empty && i_rel_vld && grant_found;
`else
        bypass_take = 1'b0;
`endif
        pop         = in_run && grant_found && !list_empty;
        grant       = pop || bypass_take;
        push        = in_run && i_rel_vld && !list_full && !bypass_take;
        rel_err_set = i_rel_vld && (!in_run || list_full);
        grant_data  = bypass_take ? i_rel_addr : free_list_q[rd_ptr_q];
    end

    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        list_we    = 1'b0;
        list_waddr = wr_ptr_q;
        list_wdata = i_rel_addr;

        if (!in_run) begin
            list_we    = 1'b1;
            list_waddr = init_cnt_q;
            list_wdata = init_cnt_q;
            if (init_cnt_q == LAST_IDX) begin
                state_d    = ST_RUN;
                init_cnt_d = '0;
                count_d    = CNT_FULL;
                rd_ptr_d   = '0;
                wr_ptr_d   = '0;
            end else begin
                init_cnt_d = init_cnt_q + 1'b1;
            end
        end else begin
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            if (push) begin
                list_we  = 1'b1;
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (push && !pop) begin
                count_d = count_q + 1'b1;
            end else if (pop && !push) begin
                count_d = count_q - 1'b1;
            end
        end

        // A fresh pulse in the grant cycle re-arms the channel rather than being lost.
        pending_d      = (pending_q & ~(grant ? grant_onehot : '0)) | i_addr_req;
        rr_ptr_d       = grant ? rr_sum[PTR_W-1:0] : rr_ptr_q;
        blk_addr_d     = grant ? grant_data : blk_addr_q;
        blk_addr_vld_d = grant ? grant_onehot : '0;
        ready_d        = in_run;
        rel_err_d      = rel_err_q | rel_err_set;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q        <= ST_INIT;
            init_cnt_q     <= '0;
            rd_ptr_q       <= '0;
            wr_ptr_q       <= '0;
            count_q        <= '0;
            pending_q      <= '0;
            rr_ptr_q       <= '0;
            blk_addr_q     <= '0;
            blk_addr_vld_q <= '0;
            ready_q        <= 1'b0;
            rel_err_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            init_cnt_q     <= init_cnt_d;
            rd_ptr_q       <= rd_ptr_d;
            wr_ptr_q       <= wr_ptr_d;
            count_q        <= count_d;
            pending_q      <= pending_d;
            rr_ptr_q       <= rr_ptr_d;
            blk_addr_q     <= blk_addr_d;
            blk_addr_vld_q <= blk_addr_vld_d;
            ready_q        <= ready_d;
            rel_err_q      <= rel_err_d;
        end
    end

    // Storage array is left unreset; INIT rewrites every entry after each reset.
    always_ff @(posedge i_clk) begin
        if (list_we) begin
            free_list_q[list_waddr] <= list_wdata;
        end
    end

    assign o_blk_addr     = blk_addr_q;
    assign o_blk_addr_vld = blk_addr_vld_q;
    assign o_ready        = ready_q;
    assign o_rel_err      = rel_err_q;
    assign o_free_cnt     = count_q;

endmodule

// File: tb/tb_blk_addr_alloc.sv
// Directed self-checking bench for blk_addr_alloc with hand-computed grant order, addresses and counts.
// Expected bypass latency follows whether BLK_ALLOC_BYPASS_EN is defined for the build.
module tb_blk_addr_alloc;

    localparam int PORT_NUM = 16;
    localparam int ADDR_W   = 11;
    localparam int BLK_NUM  = 2048;

    logic                clk;
    logic                rstN;
    logic [PORT_NUM-1:0] addrReq;
    logic [ADDR_W-1:0]   blkAddr;
    logic [PORT_NUM-1:0] blkAddrVld;
    logic                relVld;
    logic [ADDR_W-1:0]   relAddr;
    logic                ready;
    logic                relErr;
    logic [ADDR_W:0]     freeCnt;

    int testsRun    = 0;
    int testsFailed = 0;

    blk_addr_alloc #(
        .PORT_NUM (PORT_NUM),
        .ADDR_W   (ADDR_W),
        .BLK_NUM  (BLK_NUM)
    ) dut (
        .i_clk          (clk),
        .i_rst_n        (rstN),
        .i_addr_req     (addrReq),
        .o_blk_addr     (blkAddr),
        .o_blk_addr_vld (blkAddrVld),
        .i_rel_vld      (relVld),
        .i_rel_addr     (relAddr),
        .o_ready        (ready),
        .o_rel_err      (relErr),
        .o_free_cnt     (freeCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // Drive one cycle of inputs from a negedge, let one rising edge pass, return at the next negedge.
    task automatic applyStimulus(input logic [PORT_NUM-1:0] reqIn, input logic relVldIn,
                                 input logic [ADDR_W-1:0] relAddrIn);
        addrReq = reqIn;
        relVld  = relVldIn;
        relAddr = relAddrIn;
        @(negedge clk);
        addrReq = '0;
        relVld  = 1'b0;
        relAddr = '0;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus('0, 1'b0, '0);
        end
    endtask

    initial begin
        int grants;
        int seqErrs;
        int expAddr;
        logic [PORT_NUM-1:0] reqNow;
        logic [PORT_NUM-1:0] expVld;

        rstN    = 1'b0;
        addrReq = '0;
        relVld  = 1'b0;
        relAddr = '0;
        repeat (3) @(negedge clk);

        checkOutput("rstAddr",    32'(blkAddr),    32'h0);
        checkOutput("rstVld",     32'(blkAddrVld), 32'h0);
        checkOutput("rstReady",   32'(ready),      32'h0);
        checkOutput("rstRelErr",  32'(relErr),     32'h0);
        checkOutput("rstFreeCnt", 32'(freeCnt),    32'h0);

        // Initialisation: ready stays low through BLK_NUM edges, rises on the next one.
        rstN = 1'b1;
        idleCycles(1);
        checkOutput("initFreeCnt0", 32'(freeCnt), 32'h0);
        idleCycles(BLK_NUM - 1);
        checkOutput("initReadyLow", 32'(ready),   32'h0);
        checkOutput("initFreeFull", 32'(freeCnt), 32'(BLK_NUM));
        idleCycles(1);
        checkOutput("initReadyHigh", 32'(ready), 32'h1);

        // Three simultaneous requests, served in port order on consecutive cycles.
        applyStimulus(16'h0007, 1'b0, '0);
        checkOutput("req3NoEarlyGrant", 32'(blkAddrVld), 32'h0);
        idleCycles(1);
        checkOutput("p0Vld",  32'(blkAddrVld), 32'h0001);
        checkOutput("p0Addr", 32'(blkAddr),    32'h0);
        idleCycles(1);
        checkOutput("p1Vld",  32'(blkAddrVld), 32'h0002);
        checkOutput("p1Addr", 32'(blkAddr),    32'h1);
        idleCycles(1);
        checkOutput("p2Vld",  32'(blkAddrVld), 32'h0004);
        checkOutput("p2Addr", 32'(blkAddr),    32'h2);
        checkOutput("freeCnt2045", 32'(freeCnt), 32'd2045);
        idleCycles(1);
        checkOutput("vldPulseEnds", 32'(blkAddrVld), 32'h0);

        // Ports 3 and 5 re-pulse after every grant; grants must alternate.
        applyStimulus(16'h0028, 1'b0, '0);
        reqNow  = '0;
        seqErrs = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(reqNow, 1'b0, '0);
            expVld = (i % 2 == 0) ? 16'h0008 : 16'h0020;
            if (blkAddrVld !== expVld || blkAddr !== ADDR_W'(3 + i)) begin
                seqErrs++;
            end
            reqNow = blkAddrVld;
        end
        checkOutput("rrAlternate", 32'(seqErrs), 32'h0);
        idleCycles(1);
        checkOutput("rrTailVld",  32'(blkAddrVld), 32'h0008);
        checkOutput("rrTailAddr", 32'(blkAddr),    32'd11);
        idleCycles(1);
        checkOutput("freeCnt2036", 32'(freeCnt), 32'd2036);

        // Drain the list through port 0 held high.
        grants  = 0;
        seqErrs = 0;
        expAddr = 12;
        for (int i = 0; i < 2038; i++) begin
            applyStimulus((i < 2036) ? 16'h0001 : 16'h0000, 1'b0, '0);
            if (blkAddrVld == 16'h0001) begin
                if (blkAddr !== ADDR_W'(expAddr)) seqErrs++;
                expAddr++;
                grants++;
            end else if (blkAddrVld != '0) begin
                seqErrs++;
            end
        end
        checkOutput("drainGrants",   32'(grants),  32'd2036);
        checkOutput("drainSeq",      32'(seqErrs), 32'h0);
        checkOutput("drainLastAddr", 32'(blkAddr), 32'd2047);
        checkOutput("drainEmpty",    32'(freeCnt), 32'h0);

        // Empty list: port 7 waits, then receives the released address.
        applyStimulus(16'h0080, 1'b0, '0);
        idleCycles(3);
        checkOutput("emptyNoGrant", 32'(blkAddrVld), 32'h0);
        applyStimulus('0, 1'b1, 11'h02A);
`ifdef BLK_ALLOC_BYPASS_EN
        checkOutput("bypassVld",     32'(blkAddrVld), 32'h0080);
        checkOutput("bypassAddr",    32'(blkAddr),    32'h02A);
        checkOutput("bypassFreeCnt", 32'(freeCnt),    32'h0);
`else
        checkOutput("relNoSameCycle", 32'(blkAddrVld), 32'h0);
        checkOutput("relFreeCnt1",    32'(freeCnt),    32'h1);
        idleCycles(1);
        checkOutput("relGrantVld",  32'(blkAddrVld), 32'h0080);
        checkOutput("relGrantAddr", 32'(blkAddr),    32'h02A);
        checkOutput("relFreeCnt0",  32'(freeCnt),    32'h0);
`endif
        idleCycles(1);

        // Refill three entries, start grants on ports 1..4, then reset during the first grant.
        applyStimulus('0, 1'b1, 11'h100);
        applyStimulus('0, 1'b1, 11'h101);
        applyStimulus('0, 1'b1, 11'h102);
        checkOutput("refillCnt", 32'(freeCnt), 32'h3);
        applyStimulus(16'h001E, 1'b0, '0);
        idleCycles(1);
        checkOutput("wrapGrantVld",  32'(blkAddrVld), 32'h0002);
        checkOutput("wrapGrantAddr", 32'(blkAddr),    32'h100);
        rstN = 1'b0;
        #1;
        checkOutput("midRstAddr",    32'(blkAddr),    32'h0);
        checkOutput("midRstVld",     32'(blkAddrVld), 32'h0);
        checkOutput("midRstReady",   32'(ready),      32'h0);
        checkOutput("midRstFreeCnt", 32'(freeCnt),    32'h0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;

        // A request during INIT is held and served first once running.
        applyStimulus(16'h0200, 1'b0, '0);
        idleCycles(BLK_NUM - 1);
        checkOutput("reinitReadyLow", 32'(ready),      32'h0);
        checkOutput("reinitNoGrant",  32'(blkAddrVld), 32'h0);
        idleCycles(1);
        checkOutput("reinitReady",     32'(ready),      32'h1);
        checkOutput("reinitGrantVld",  32'(blkAddrVld), 32'h0200);
        checkOutput("reinitGrantAddr", 32'(blkAddr),    32'h0);
        checkOutput("reinitFreeCnt",   32'(freeCnt),    32'd2047);

        // Overflowing release is dropped and the error flag sticks.
        applyStimulus('0, 1'b1, 11'h5A5);
        checkOutput("refillFull",   32'(freeCnt), 32'(BLK_NUM));
        checkOutput("noErrYet",     32'(relErr),  32'h0);
        applyStimulus('0, 1'b1, 11'h010);
        checkOutput("ovfErr",       32'(relErr),  32'h1);
        checkOutput("ovfFreeCnt",   32'(freeCnt), 32'(BLK_NUM));
        idleCycles(2);
        checkOutput("ovfErrSticky", 32'(relErr),  32'h1);

        // Grant and release in the same cycle leave the count unchanged.
        applyStimulus(16'h0004, 1'b0, '0);
        idleCycles(1);
        checkOutput("p2GrantAddr", 32'(blkAddr), 32'h1);
        checkOutput("cnt2047",     32'(freeCnt), 32'd2047);
        applyStimulus(16'h0008, 1'b0, '0);
        applyStimulus('0, 1'b1, 11'h077);
        checkOutput("sameCycVld",     32'(blkAddrVld), 32'h0008);
        checkOutput("sameCycAddr",    32'(blkAddr),    32'h2);
        checkOutput("sameCycFreeCnt", 32'(freeCnt),    32'd2047);

        // Release during INIT is dropped and flagged.
        @(negedge clk);
        rstN = 1'b0;
        #1;
        checkOutput("rstClearsErr", 32'(relErr), 32'h0);
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        applyStimulus('0, 1'b1, 11'h033);
        checkOutput("initRelErr",     32'(relErr),  32'h1);
        checkOutput("initRelFreeCnt", 32'(freeCnt), 32'h0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
